// File: rtl/nvme_sq_arbiter.sv
// NVMe submission-queue arbiter: burst-limited round robin over NUM_SQ rings, one fetch request at a time.
// Optional `NVME_ADMIN_PRIO_EN: a non-empty admin queue (q0) wins every SELECT and does not move rr_ptr.
module nvme_sq_arbiter #(
    parameter int unsigned QID_W   = 2,
    parameter int unsigned PTR_W   = 4,
    parameter int unsigned BURST_W = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ctrl_en,
    input  logic                        db_valid,
    input  logic [QID_W-1:0]            db_qid,
    input  logic [PTR_W-1:0]            db_tail,
    input  logic [BURST_W-1:0]          arb_burst,
    output logic                        fetch_valid,
    output logic [QID_W-1:0]            fetch_qid,
    output logic [PTR_W-1:0]            fetch_slot,
    input  logic                        fetch_ready,
    output logic [(2**QID_W)*PTR_W-1:0] sq_head,
    output logic                        arb_busy
);

    localparam int unsigned NUM_SQ = 2**QID_W;

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   head [NUM_SQ];
    logic [PTR_W-1:0]   tail [NUM_SQ];
    logic [QID_W-1:0]   rr_ptr;
    logic [BURST_W-1:0] burst_cnt;

    logic [NUM_SQ-1:0]  nonempty;
    logic               any_pending;
    logic [QID_W-1:0]   grant;
    logic               grant_found;
    logic [QID_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   next_head;
    logic               burst_end;

    always_comb begin
        nonempty = '0;
        for (int unsigned q = 0; q < NUM_SQ; q++) begin
            nonempty[q] = (head[q] != tail[q]);
        end
        any_pending = |nonempty;
    end

    always_comb begin
        grant       = rr_ptr;
        grant_found = 1'b0;
        scan_idx    = rr_ptr;
        for (int unsigned i = 0; i < NUM_SQ; i++) begin
            scan_idx = rr_ptr + QID_W'(i);
            if (!grant_found && nonempty[scan_idx]) begin
                grant       = scan_idx;
                grant_found = 1'b1;
            end
        end
`ifdef NVME_ADMIN_PRIO_EN
        if (nonempty[0]) begin
            grant       = '0;
            grant_found = 1'b1;
        end
`endif
    end

    // Empty check uses the pre-edge tail; a same-cycle doorbell is seen on the queue's next turn.
    assign next_head = head[fetch_qid] + PTR_W'(1);
    assign burst_end = (burst_cnt == arb_burst) || (next_head == tail[fetch_qid]);

    always_comb begin
        sq_head = '0;
        for (int unsigned q = 0; q < NUM_SQ; q++) begin
            sq_head[q*PTR_W +: PTR_W] = head[q];
        end
    end

    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            fetch_valid <= 1'b0;
            fetch_qid   <= '0;
            fetch_slot  <= '0;
            for (int unsigned q = 0; q < NUM_SQ; q++) begin
                head[q] <= '0;
                tail[q] <= '0;
            end
        end else if (!ctrl_en) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            fetch_valid <= 1'b0;
            fetch_qid   <= '0;
            fetch_slot  <= '0;
            for (int unsigned q = 0; q < NUM_SQ; q++) begin
                head[q] <= '0;
                tail[q] <= '0;
            end
        end else begin
            if (db_valid) begin
                tail[db_qid] <= db_tail;
            end
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (grant_found) begin
                        fetch_qid   <= grant;
                        fetch_slot  <= head[grant];
                        fetch_valid <= 1'b1;
                        burst_cnt   <= '0;
                        state       <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (fetch_ready) begin
                        head[fetch_qid] <= next_head;
                        burst_cnt       <= burst_cnt + BURST_W'(1);
                        if (burst_end) begin
                            fetch_valid <= 1'b0;
                            state       <= IDLE;
`ifdef NVME_ADMIN_PRIO_EN
                            if (fetch_qid != '0) begin
                                rr_ptr <= fetch_qid + QID_W'(1);
                            end
`else
                            rr_ptr <= fetch_qid + QID_W'(1);
`endif
                        end else begin
                            fetch_slot <= next_head;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvme_sq_arbiter.sv
// Self-checking bench for nvme_sq_arbiter: directed scenarios plus randomized traffic against an integer reference model.
module tb_nvme_sq_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_en = 1'b1;
    logic        db_valid = 1'b0;
    logic [1:0]  db_qid = '0;
    logic [3:0]  db_tail = '0;
    logic [2:0]  arb_burst = 3'd7;
    logic        fetch_valid;
    logic [1:0]  fetch_qid;
    logic [3:0]  fetch_slot;
    logic        fetch_ready = 1'b0;
    logic [15:0] sq_head;
    logic        arb_busy;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 0;
    int log_q[$];

    nvme_sq_arbiter #(.QID_W(2), .PTR_W(4), .BURST_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_en(ctrl_en),
        .db_valid(db_valid), .db_qid(db_qid), .db_tail(db_tail), .arb_burst(arb_burst),
        .fetch_valid(fetch_valid), .fetch_qid(fetch_qid), .fetch_slot(fetch_slot),
        .fetch_ready(fetch_ready), .sq_head(sq_head), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phases 0=idle 1=select 2=issue, plain modular integer arithmetic.
    int m_head[4], m_tail[4], m_rr, m_phase, m_q, m_cnt;
    bit m_valid;

    function automatic void m_clear();
        for (int k = 0; k < 4; k++) begin m_head[k] = 0; m_tail[k] = 0; end
        m_rr = 0; m_phase = 0; m_q = 0; m_cnt = 0; m_valid = 0;
    endfunction

    function automatic int m_packed();
        int p = 0;
        for (int k = 0; k < 4; k++) p += m_head[k] << (4 * k);
        return p;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int pend, g, q;
        if (!reset_n || !ctrl_en) begin
            m_clear();
        end else begin
            pend = 0;
            for (int k = 0; k < 4; k++) if (m_head[k] != m_tail[k]) pend = 1;
            case (m_phase)
                0: if (pend != 0) m_phase = 1;
                1: begin
                    g = -1;
                    for (int k = 0; k < 4; k++) begin
                        q = (m_rr + k) % 4;
                        if (g < 0 && m_head[q] != m_tail[q]) g = q;
                    end
`ifdef NVME_ADMIN_PRIO_EN
                    if (m_head[0] != m_tail[0]) g = 0;
`endif
                    if (g < 0) m_phase = 0;
                    else begin m_q = g; m_cnt = 0; m_valid = 1; m_phase = 2; end
                end
                default: if (fetch_ready) begin
                    m_head[m_q] = (m_head[m_q] + 1) % 16;
                    m_cnt++;
                    if (m_cnt == int'(arb_burst) + 1 || m_head[m_q] == m_tail[m_q]) begin
                        m_valid = 0; m_phase = 0;
`ifdef NVME_ADMIN_PRIO_EN
                        if (m_q != 0) m_rr = (m_q + 1) % 4;
`else
                        m_rr = (m_q + 1) % 4;
`endif
                    end
                end
            endcase
            if (db_valid) m_tail[db_qid] = int'(db_tail);
        end
    end

    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            check("fetch_valid", int'(fetch_valid), int'(m_valid));
            check("arb_busy", int'(arb_busy), (m_phase != 0) ? 1 : 0);
            check("sq_head", int'(sq_head), m_packed());
            if (m_valid) begin
                check("fetch_qid", int'(fetch_qid), m_q);
                check("fetch_slot", int'(fetch_slot), m_head[m_q]);
            end
            if (ctrl_en && fetch_valid && fetch_ready) log_q.push_back(int'(fetch_qid) * 16 + int'(fetch_slot));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doorbell(input int q, input int t);
        db_valid = 1'b1; db_qid = 2'(q); db_tail = 4'(t);
        tick();
        db_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0, idle = 0;
        while (idle < 3 && n < 300) begin
            tick(); n++;
            idle = arb_busy ? 0 : idle + 1;
        end
        if (n >= 300) check("drain_timeout", 1, 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!fetch_valid && n < 20) begin tick(); n++; end
        if (n >= 20) check("valid_timeout", 1, 0);
    endtask

    task automatic ctrl_clear();
        ctrl_en = 1'b0; tick(); ctrl_en = 1'b1; log_q.delete();
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check({tag, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) check(tag, log_q[i], exp[i]);
    endtask

    initial begin
        int lat, hq, hs, hh;
        int exp[$];
        #12;
        reset_n = 1'b1;
        check("rst_valid", int'(fetch_valid), 0);
        check("rst_qid", int'(fetch_qid), 0);
        check("rst_slot", int'(fetch_slot), 0);
        check("rst_head", int'(sq_head), 0);
        check("rst_busy", int'(arb_busy), 0);
        mon_en = 1;
        tick();

        // Single doorbell, latency and consecutive issue.
        fetch_ready = 1'b1; arb_burst = 3'd7;
        doorbell(1, 3);
        lat = 0;
        while (!fetch_valid && lat < 10) begin tick(); lat++; end
        check("latency", lat, 2);
        drain();
        check("q1_head", int'(sq_head[7:4]), 3);
        exp = '{16, 17, 18};
        check_log("t1_order", exp);

        // Two queues, burst of two each.
        ctrl_clear();
        arb_burst = 3'd1;
        doorbell(0, 4);
        doorbell(2, 4);
        drain();
`ifdef NVME_ADMIN_PRIO_EN
        exp = '{0, 1, 2, 3, 32, 33, 34, 35};
`else
        exp = '{0, 1, 32, 33, 2, 3, 34, 35};
`endif
        check_log("t2_order", exp);

        // Ring wrap on q3.
        ctrl_clear();
        arb_burst = 3'd7;
        doorbell(3, 14);
        drain();
        log_q.delete();
        doorbell(3, 2);
        drain();
        exp = '{62, 63, 48, 49};
        check_log("t3_wrap", exp);
        check("q3_head", int'(sq_head[15:12]), 2);

        // Back-pressure: request held stable.
        ctrl_clear();
        fetch_ready = 1'b0;
        doorbell(2, 1);
        wait_valid();
        hq = int'(fetch_qid); hs = int'(fetch_slot); hh = int'(sq_head);
        repeat (5) begin
            tick();
            check("bp_valid", int'(fetch_valid), 1);
            check("bp_qid", int'(fetch_qid), hq);
            check("bp_slot", int'(fetch_slot), hs);
            check("bp_head", int'(sq_head), hh);
        end
        fetch_ready = 1'b1;
        drain();
        check("bp_done_head", int'(sq_head[11:8]), 1);

        // Controller disable aborts and ignores doorbells.
        ctrl_clear();
        fetch_ready = 1'b0;
        doorbell(1, 5);
        wait_valid();
        check("abort_pre_valid", int'(fetch_valid), 1);
        ctrl_en = 1'b0;
        tick();
        check("abort_valid", int'(fetch_valid), 0);
        check("abort_head", int'(sq_head), 0);
        doorbell(2, 3);
        repeat (3) tick();
        ctrl_en = 1'b1; fetch_ready = 1'b1;
        log_q.delete();
        repeat (6) tick();
        check("dis_no_fetch", int'(fetch_valid), 0);
        check("dis_no_log", log_q.size(), 0);

        // Admin priority with rr_ptr at 2.
        ctrl_clear();
        arb_burst = 3'd7;
        doorbell(1, 1);
        drain();
        log_q.delete();
        doorbell(0, 1);
        doorbell(2, 1);
        drain();
`ifdef NVME_ADMIN_PRIO_EN
        exp = '{0, 32};
`else
        exp = '{32, 0};
`endif
        check_log("t6_prio", exp);

        // Randomized traffic, including aborts and one async reset.
        ctrl_clear();
        for (int i = 0; i < 3000; i++) begin
            db_valid = ($urandom_range(0, 99) < 30);
            db_qid = 2'($urandom_range(0, 3));
            db_tail = 4'($urandom_range(0, 15));
            fetch_ready = ($urandom_range(0, 99) < 70);
            ctrl_en = ($urandom_range(0, 199) != 0);
            if (m_phase == 0 && $urandom_range(0, 15) == 0) arb_burst = 3'($urandom_range(0, 7));
            if (i == 1500) begin
                #3 reset_n = 1'b0;
                #2;
                check("async_valid", int'(fetch_valid), 0);
                check("async_head", int'(sq_head), 0);
                #2 reset_n = 1'b1;
            end
            tick();
        end
        db_valid = 1'b0; ctrl_en = 1'b1; fetch_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
